seg_scan_ctrl: RTL and testbench

- Parametrised successor to the 4-digit result display/browse block.
- Drives an N-digit multiplexed seven-segment display from the solver outputs (comp, cnt, ord).
- Debounces all five buttons and maintains a browse index with saturate or wrap mode, plus jump-to-first/last.
- Converts the displayed number to BCD sequentially; the scan buffer is double-buffered, so the display never shows a partial update.

---
 rtl/seg_pkg.sv | 71 +++++++
 rtl/seg_scan_ctrl_if.sv | 20 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/seg_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================
// seg_pkg: glyph codes, direction codes, glyph helpers. rev 1.0
// ============================================================
package seg_pkg;

   // Active-low dp + g..a; bit 7 high keeps the decimal point off.
   localparam logic [7:0] GLY_0     = 8'hC0;
   localparam logic [7:0] GLY_1     = 8'hF9;
   localparam logic [7:0] GLY_2     = 8'hA4;
   localparam logic [7:0] GLY_3     = 8'hB0;
   localparam logic [7:0] GLY_4     = 8'h99;
   localparam logic [7:0] GLY_5     = 8'h92;
   localparam logic [7:0] GLY_6     = 8'h82;
   localparam logic [7:0] GLY_7     = 8'hF8;
   localparam logic [7:0] GLY_8     = 8'h80;
   localparam logic [7:0] GLY_9     = 8'h90;
   localparam logic [7:0] GLY_U     = 8'hC1;
   localparam logic [7:0] GLY_P     = 8'h8C;
   localparam logic [7:0] GLY_D     = 8'hA1;
   localparam logic [7:0] GLY_O     = 8'hA3;
   localparam logic [7:0] GLY_L     = 8'hC7;
   localparam logic [7:0] GLY_E     = 8'h86;
   localparam logic [7:0] GLY_R     = 8'hAF;
   localparam logic [7:0] GLY_I     = 8'hCF;
   localparam logic [7:0] GLY_S     = 8'h92;
   localparam logic [7:0] GLY_DASH  = 8'hBF;
   localparam logic [7:0] GLY_BLANK = 8'hFF;

   localparam logic [1:0] DIR_UP    = 2'b01;
   localparam logic [1:0] DIR_DOWN  = 2'b10;
   localparam logic [1:0] DIR_LEFT  = 2'b11;
   localparam logic [1:0] DIR_RIGHT = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } bcd_state_t;

   function automatic logic [15:0] dir_glyphs(input logic [1:0] code);
      logic [15:0] g;
      case (code)
         DIR_UP:   g = {GLY_U, GLY_P};
         DIR_DOWN: g = {GLY_D, GLY_O};
         DIR_LEFT: g = {GLY_L, GLY_E};
         default:  g = {GLY_R, GLY_I};
      endcase
      return g;
   endfunction

   function automatic logic [7:0] bcd_glyph(input logic [3:0] nib);
      logic [7:0] g;
      case (nib)
         4'd0:    g = GLY_0;
         4'd1:    g = GLY_1;
         4'd2:    g = GLY_2;
         4'd3:    g = GLY_3;
         4'd4:    g = GLY_4;
         4'd5:    g = GLY_5;
         4'd6:    g = GLY_6;
         4'd7:    g = GLY_7;
         4'd8:    g = GLY_8;
         4'd9:    g = GLY_9;
         default: g = GLY_DASH;
      endcase
      return g;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================
// seg_scan_ctrl_if: solver inputs, buttons and display outputs. rev 1.0
// ============================================================
interface seg_scan_ctrl_if #(
   parameter int DIGITS = 4,
   parameter int IDX_W  = 5,
   parameter int N_ENT  = 22
);
   logic                   comp;
   logic [IDX_W-1:0]       cnt;
   logic [2*N_ENT-1:0]     ord;
   logic [4:0]             btn;
   logic [DIGITS+7:0]      seg;
   logic [IDX_W-1:0]       num;

   modport master (output comp, cnt, ord, btn, input seg, num);
   modport slave  (input comp, cnt, ord, btn, output seg, num);
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================
// btn_debounce: 2-flop sync, stability counter, press pulse. rev 1.0
// ============================================================
module btn_debounce #(
   parameter int DEB = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic press
);
   localparam int CW = $clog2(DEB + 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_clean;
   logic [CW-1:0] r_cnt;
   logic          w_settle;

   // Asserted on the DEB-th consecutive differing sample; clean follows on this edge.
   assign w_settle = (r_s2 != r_clean) && (r_cnt == CW'(DEB - 1));
   assign press    = w_settle & r_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_clean <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1 <= raw;
         r_s2 <= r_s1;
         if (r_s2 == r_clean) begin
            r_cnt <= '0;
         end else if (w_settle) begin
            r_cnt   <= '0;
            r_clean <= r_s2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================
// seg_scan_ctrl: browse index, sequential BCD, scanned N-digit display. rev 1.0
// ============================================================
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int IDX_W  = 5,
   parameter int N_ENT  = 22,
   parameter int DIV    = 1001,
   parameter int DEB    = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   seg_scan_ctrl_if.slave bus
);
   localparam int NUM_D = DIGITS - 2;
   localparam int SH_W  = 4 * NUM_D + IDX_W;
   localparam int IT_W  = $clog2(IDX_W + 1);
   localparam int DV_W  = $clog2(DIV);
   localparam int DG_W  = $clog2(DIGITS);

   logic [4:0]        w_press;
   logic [IDX_W-1:0]  r_num;
   logic              r_wrap;
   logic [IDX_W-1:0]  w_value;
   logic [1:0]        w_dir;
   logic [15:0]       w_text;

   bcd_state_t        r_state;
   logic [IDX_W-1:0]  r_val;
   logic [IDX_W-1:0]  r_last_val;
   logic [15:0]       r_text;
   logic [15:0]       r_last_text;
   logic [SH_W-1:0]   r_sh;
   logic [IT_W-1:0]   r_iter;
   logic [7:0]        r_buf [DIGITS];

   logic [DV_W-1:0]   r_div;
   logic [DG_W-1:0]   r_digit;
   logic [DIGITS+7:0] r_seg;
   logic [DIGITS-1:0] w_en;

   for (genvar gi = 0; gi < 5; gi++) begin : g_btn
      btn_debounce #(.DEB(DEB)) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (bus.btn[gi]),
         .press (w_press[gi])
      );
   end

   // A shrinking cnt clamps the index before any button action is considered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_num  <= '0;
         r_wrap <= 1'b0;
      end else begin
         if (w_press[0]) r_wrap <= ~r_wrap;
         if (r_num > bus.cnt) begin
            r_num <= bus.cnt;
         end else if (bus.comp) begin
            if (w_press[4])
               r_num <= (r_num < bus.cnt) ? r_num + 1'b1 : (r_wrap ? '0 : r_num);
            else if (w_press[3])
               r_num <= (r_num != '0) ? r_num - 1'b1 : (r_wrap ? bus.cnt : r_num);
            else if (w_press[2])
               r_num <= '0;
            else if (w_press[1])
               r_num <= bus.cnt;
         end
      end
   end

   assign bus.num = r_num;
   assign w_value = bus.comp ? r_num : bus.cnt;

   always_comb begin
      w_dir = DIR_RIGHT;
      for (int k = 0; k < N_ENT; k++)
         if (int'(r_num) == k) w_dir = bus.ord[2*k +: 2];
   end

   assign w_text = !bus.comp            ? {GLY_S, GLY_O} :
                   (int'(r_num) >= N_ENT) ? {GLY_DASH, GLY_DASH} :
                   dir_glyphs(w_dir);

   function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] s);
      logic [SH_W-1:0] t;
      t = s;
      for (int i = 0; i < NUM_D; i++)
         if (t[IDX_W+4*i +: 4] >= 4'd5)
            t[IDX_W+4*i +: 4] = t[IDX_W+4*i +: 4] + 4'd3;
      return {t[SH_W-2:0], 1'b0};
   endfunction

   // last_text resets to all ones so the first pass after reset always converts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_val       <= '0;
         r_last_val  <= '0;
         r_text      <= '1;
         r_last_text <= '1;
         r_sh        <= '0;
         r_iter      <= '0;
         for (int i = 0; i < DIGITS; i++) r_buf[i] <= GLY_BLANK;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if ((w_value != r_last_val) || (w_text != r_last_text)) begin
                  r_val   <= w_value;
                  r_text  <= w_text;
                  r_sh    <= {{(4*NUM_D){1'b0}}, w_value};
                  r_iter  <= '0;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_sh   <= dd_step(r_sh);
               r_iter <= r_iter + 1'b1;
               if (r_iter == IT_W'(IDX_W - 1)) r_state <= ST_DONE;
            end
            ST_DONE: begin
               for (int i = 0; i < NUM_D; i++)
                  r_buf[i] <= bcd_glyph(r_sh[IDX_W+4*i +: 4]);
               r_buf[DIGITS-1] <= r_text[15:8];
               r_buf[DIGITS-2] <= r_text[7:0];
               r_last_val      <= r_val;
               r_last_text     <= r_text;
               r_state         <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_en = ~({{(DIGITS-1){1'b0}}, 1'b1} << r_digit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div   <= '0;
         r_digit <= '0;
         r_seg   <= '1;
      end else if (r_div == DV_W'(DIV - 1)) begin
         r_div   <= '0;
         r_digit <= (r_digit == DG_W'(DIGITS - 1)) ? '0 : r_digit + 1'b1;
         r_seg   <= {w_en, r_buf[r_digit]};
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   assign bus.seg = r_seg;
endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================
// tb_seg_scan_ctrl: directed + randomized checks against a behavioural model. rev 1.0
// ============================================================
module tb_seg_scan_ctrl;
   localparam int DIGITS = 4;
   localparam int IDX_W  = 5;
   localparam int N_ENT  = 22;
   localparam int DIV    = 12;
   localparam int DEB    = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   int                 m_num;
   int                 m_cnt;
   logic               m_wrap;
   logic               m_comp;
   logic [2*N_ENT-1:0] m_ord;

   seg_scan_ctrl_if #(.DIGITS(DIGITS), .IDX_W(IDX_W), .N_ENT(N_ENT)) bus ();

   seg_scan_ctrl #(
      .DIGITS (DIGITS),
      .IDX_W  (IDX_W),
      .N_ENT  (N_ENT),
      .DIV    (DIV),
      .DEB    (DEB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Independent glyph table: active-high g..a patterns, inverted for the display.
   function automatic logic [7:0] gly(input byte c);
      logic [6:0] p;
      case (c)
         "0": p = 7'h3F;  "1": p = 7'h06;  "2": p = 7'h5B;  "3": p = 7'h4F;
         "4": p = 7'h66;  "5": p = 7'h6D;  "6": p = 7'h7D;  "7": p = 7'h07;
         "8": p = 7'h7F;  "9": p = 7'h6F;  "U": p = 7'h3E;  "P": p = 7'h73;
         "d": p = 7'h5E;  "o": p = 7'h5C;  "L": p = 7'h38;  "E": p = 7'h79;
         "R": p = 7'h50;  "I": p = 7'h30;  "S": p = 7'h6D;  "-": p = 7'h40;
         default: p = 7'h00;
      endcase
      return {1'b1, ~p};
   endfunction

   function automatic string exp_text();
      logic [1:0] code;
      if (!m_comp) return "So";
      if (m_num >= N_ENT) return "--";
      code = m_ord[2*m_num +: 2];
      case (code)
         2'b01:   return "UP";
         2'b10:   return "do";
         2'b11:   return "LE";
         default: return "RI";
      endcase
   endfunction

   function automatic string model_string();
      int v;
      v = m_comp ? m_num : m_cnt;
      return $sformatf("%s%02d", exp_text(), v);
   endfunction

   task automatic set_inputs(input logic comp, input int cnt);
      bus.comp = comp;
      bus.cnt  = IDX_W'(cnt);
      m_comp   = comp;
      m_cnt    = cnt;
      if (m_num > cnt) m_num = cnt;
   endtask

   task automatic press(input logic [4:0] mask);
      bus.btn = mask;
      cycles(DEB + 4);
      bus.btn = 5'b0;
      cycles(DEB + 4);
      if (m_comp) begin
         if (mask[4])      m_num = (m_num < m_cnt) ? m_num + 1 : (m_wrap ? 0 : m_num);
         else if (mask[3]) m_num = (m_num > 0) ? m_num - 1 : (m_wrap ? m_cnt : m_num);
         else if (mask[2]) m_num = 0;
         else if (mask[1]) m_num = m_cnt;
      end
      if (mask[0]) m_wrap = ~m_wrap;
   endtask

   // Waits for the buffer to reach the scan, then reads every digit slot once.
   task automatic frame_check(input string s);
      logic [8:0]        seen [DIGITS];
      logic [DIGITS-1:0] en;
      for (int i = 0; i < DIGITS; i++) seen[i] = 9'h1FF;
      cycles(DIGITS * DIV + 3 * IDX_W);
      for (int slot = 0; slot < DIGITS; slot++) begin
         en = bus.seg[DIGITS+7:8];
         chk("en_onehot", $countones(~en), 1);
         for (int i = 0; i < DIGITS; i++)
            if (!en[i]) seen[i] = {1'b0, bus.seg[7:0]};
         cycles(DIV);
      end
      for (int i = 0; i < DIGITS; i++)
         chk($sformatf("digit%0d_%s", i, s), seen[i], {1'b0, gly(s.getc(DIGITS-1-i))});
   endtask

   initial begin
      bus.btn = 5'b0;
      m_num   = 0;
      m_wrap  = 1'b0;
      m_ord   = {$urandom, $urandom};
      bus.ord = m_ord;
      set_inputs(1'b0, 0);

      // Asynchronous reset mid-frame, then first slot timing
      cycles(3);
      rst_n = 1'b1;
      cycles(30);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_seg_async", bus.seg, 32'hFFF);
      chk("rst_num", bus.num, 0);
      cycles(2);
      rst_n = 1'b1;
      repeat (DIV - 1) @(posedge clk);
      @(negedge clk);
      chk("scan_pre", bus.seg, 32'hFFF);
      @(posedge clk);
      @(negedge clk);
      chk("scan_first_en", bus.seg[DIGITS+7:8], 4'b1110);
      chk("scan_first_dig", bus.seg[7:0], gly("0"));

      // Bouncing next button: one increment, DEB+2 edges after the stable edge
      set_inputs(1'b1, 5);
      cycles(2);
      for (int g = 0; g < 2; g++) begin
         bus.btn[4] = 1'b1;
         cycles(3);
         bus.btn[4] = 1'b0;
         cycles(3);
      end
      bus.btn[4] = 1'b1;
      repeat (DEB + 1) @(posedge clk);
      @(negedge clk);
      chk("deb_early", bus.num, 0);
      @(posedge clk);
      @(negedge clk);
      chk("deb_edge", bus.num, 1);
      cycles(10);
      bus.btn[4] = 1'b0;
      cycles(DEB + 4);
      chk("deb_once", bus.num, 1);
      m_num = 1;

      // Saturate vs wrap
      set_inputs(1'b1, 3);
      press(5'b00010);
      chk("last", bus.num, 3);
      press(5'b10000);
      chk("sat_next", bus.num, 3);
      press(5'b00001);
      press(5'b10000);
      chk("wrap_next", bus.num, 0);
      press(5'b01000);
      chk("wrap_prev", bus.num, 3);

      // Display content
      m_ord[5:4] = 2'b11;
      bus.ord    = m_ord;
      set_inputs(1'b1, 10);
      press(5'b00100);
      press(5'b10000);
      press(5'b10000);
      chk("num_two", bus.num, 2);
      frame_check("LE02");
      set_inputs(1'b0, 17);
      frame_check("So17");

      // Clamp beats a simultaneous next (wrap is on here)
      set_inputs(1'b1, 9);
      press(5'b00010);
      chk("num_nine", bus.num, 9);
      set_inputs(1'b1, 20);
      cycles(2);
      bus.btn = 5'b10000;
      repeat (DEB + 1) @(posedge clk);
      @(negedge clk);
      chk("clamp_pre", bus.num, 9);
      set_inputs(1'b1, 4);
      @(posedge clk);
      @(negedge clk);
      chk("clamp", bus.num, 4);
      bus.btn = 5'b0;
      cycles(DEB + 4);
      chk("clamp_hold", bus.num, 4);
      set_inputs(1'b1, 20);
      press(5'b11000);
      chk("next_over_prev", bus.num, 5);

      // BCD latency: buffer updates exactly IDX_W+2 edges after the value change
      set_inputs(1'b0, 0);
      cycles(40);
      set_inputs(1'b0, 31);
      repeat (IDX_W + 1) @(posedge clk);
      @(negedge clk);
      chk("bcd_hold_t", dut.r_buf[1], gly("0"));
      chk("bcd_hold_o", dut.r_buf[0], gly("0"));
      @(posedge clk);
      @(negedge clk);
      chk("bcd_new_t", dut.r_buf[1], gly("3"));
      chk("bcd_new_o", dut.r_buf[0], gly("1"));
      frame_check("So31");

      // Randomized presses, bound changes and move lists against the model
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 9) < 3) begin
            if ($urandom_range(0, 1) == 1) begin
               m_ord   = {$urandom, $urandom};
               bus.ord = m_ord;
            end
            set_inputs(($urandom_range(0, 3) != 0), $urandom_range(0, 31));
            cycles(2);
         end else begin
            press(5'($urandom_range(1, 31)));
         end
         chk("rand_num", bus.num, m_num);
         if (it % 6 == 5) frame_check(model_string());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
